// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, state type and legality helper for the load/store unit
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   // Unsigned widths exist only for loads; halfwords and words must be naturally aligned.
   function automatic logic access_ok(input logic is_load, input logic [2:0] f3,
                                      input logic [1:0] off);
      logic ok;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~off[0];
         F3_W:    ok = (off == 2'b00);
         F3_BU:   ok = is_load;
         F3_HU:   ok = is_load & ~off[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/halfword of a read word and extends it
module load_align
   import mem_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_rdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (i_off)
         2'd0:    byte_sel = i_rdata[7:0];
         2'd1:    byte_sel = i_rdata[15:8];
         2'd2:    byte_sel = i_rdata[23:16];
         default: byte_sel = i_rdata[31:24];
      endcase
      half_sel = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_funct3)
         F3_B:    o_rdata = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    o_rdata = {{16{half_sel[15]}}, half_sel};
         F3_BU:   o_rdata = {24'd0, byte_sel};
         F3_HU:   o_rdata = {16'd0, half_sel};
         default: o_rdata = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine driving a req/gnt/rvalid data bus
module mem_access_unit
   import mem_pkg::*;
#(
   parameter logic [7:0] MAX_WAIT = 8'd255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic        i_ren,
   input  logic        i_wen,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_stall,
   output logic        o_valid,
   output logic [31:0] o_rdata,
   output logic        o_fault,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_mask,
   input  logic        i_mem_gnt,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata
);

   state_t      state, state_nx;
   logic [31:0] addr_q, wdata_q, rdata_q, aligned, lane_data;
   logic [3:0]  mask_q, lane_mask;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [7:0]  cnt;
   logic        we_q, fault_q;
   logic        accept, bad, capture, timeout;

   load_align u_align (
      .i_funct3 (f3_q),
      .i_off    (off_q),
      .i_rdata  (i_mem_rdata),
      .o_rdata  (aligned)
   );

   always_comb begin
      case (i_funct3[1:0])
         2'b00: begin
            lane_mask = MASK_B << i_addr[1:0];
            lane_data = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            lane_mask = MASK_H << {i_addr[1], 1'b0};
            lane_data = {2{i_wdata[15:0]}};
         end
         default: begin
            lane_mask = MASK_W;
            lane_data = i_wdata;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      bad       = 1'b0;
      capture   = 1'b0;
      timeout   = 1'b0;
      o_stall   = 1'b0;
      o_mem_req = 1'b0;
      o_valid   = 1'b0;
      case (state)
         S_IDLE: begin
            // Reset is folded in so a held-valid instruction cannot raise stall during reset.
            if (i_valid && !i_rst && (i_ren || i_wen)) begin
               if ((i_ren ^ i_wen) && access_ok(i_ren, i_funct3, i_addr[1:0])) accept = 1'b1;
               else                                                              bad    = 1'b1;
            end
            if (accept) begin
               o_stall  = 1'b1;
               state_nx = S_REQ;
            end
         end
         S_REQ: begin
            o_stall   = 1'b1;
            o_mem_req = 1'b1;
            if (i_mem_gnt) begin
               if (we_q) state_nx = S_RESP;
               else if (i_mem_rvalid) begin
                  capture  = 1'b1;
                  state_nx = S_RESP;
               end else state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            o_stall = 1'b1;
            if (i_mem_rvalid) begin
               capture  = 1'b1;
               state_nx = S_RESP;
            end else if (cnt == MAX_WAIT - 8'd1) begin
               timeout  = 1'b1;
               state_nx = S_IDLE;
            end
         end
         S_RESP: begin
            o_valid  = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         mask_q  <= 4'd0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         cnt     <= 8'd0;
         we_q    <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         fault_q <= bad | timeout;
         if (accept) begin
            addr_q  <= {i_addr[31:2], 2'b00};
            off_q   <= i_addr[1:0];
            f3_q    <= i_funct3;
            we_q    <= i_wen;
            mask_q  <= lane_mask;
            wdata_q <= lane_data;
         end
         if (state == S_REQ)       cnt <= 8'd0;
         else if (state == S_WAIT) cnt <= cnt + 8'd1;
         if (capture)      rdata_q <= aligned;
         else if (timeout) rdata_q <= 32'd0;
      end
   end

   assign o_rdata     = rdata_q;
   assign o_fault     = fault_q;
   assign o_mem_we    = we_q;
   assign o_mem_addr  = addr_q;
   assign o_mem_wdata = wdata_q;
   assign o_mem_mask  = mask_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and randomized checks of mem_access_unit against a behavioural model
module tb_mem_access_unit;

   logic        clk, rst, valid, ren, wen, gnt, rvalid;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, mem_rdata;
   logic        stall, ovalid, fault, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_mask;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_rdata = 32'd0;

   mem_access_unit #(.MAX_WAIT(8'd4)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_valid      (valid),
      .i_ren        (ren),
      .i_wen        (wen),
      .i_funct3     (funct3),
      .i_addr       (addr),
      .i_wdata      (wdata),
      .o_stall      (stall),
      .o_valid      (ovalid),
      .o_rdata      (rdata),
      .o_fault      (fault),
      .o_mem_req    (mem_req),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .o_mem_mask   (mem_mask),
      .i_mem_gnt    (gnt),
      .i_mem_rvalid (rvalid),
      .i_mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_legal(input bit r, input bit w, input logic [2:0] f3,
                                    input logic [31:0] a);
      int nbytes;
      if (r == w) return 1'b0;
      if (f3 == 3'd3 || f3 >= 3'd6) return 1'b0;
      if (w && f3 >= 3'd4) return 1'b0;
      nbytes = 1 << f3[1:0];
      return (a % nbytes) == 0;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
      int unsigned off;
      logic [31:0] v;
      off = a % 4;
      if (f3[1:0] == 2'd0) begin
         v = (rd >> (8 * off)) & 32'hFF;
         if (!f3[2] && v >= 32'd128) v = v - 32'd256;
      end else if (f3[1:0] == 2'd1) begin
         v = (rd >> (8 * off)) & 32'hFFFF;
         if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
      end else v = rd;
      return v;
   endfunction

   function automatic logic [31:0] exp_mask(input logic [2:0] f3, input logic [31:0] a);
      if (f3[1:0] == 2'd0) return 32'd1 << (a % 4);
      if (f3[1:0] == 2'd1) return 32'd3 << (a % 4);
      return 32'd15;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
      if (f3[1:0] == 2'd0) return (wd & 32'hFF) * 32'h01010101;
      if (f3[1:0] == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
      return wd;
   endfunction

   // rdly: WAIT cycles before rvalid (0 = with gnt), negative = never (timeout).
   task automatic run_access(input bit r, input bit w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int gdly, input int rdly);
      bit legal;
      int nk;
      legal = exp_legal(r, w, f3, a);
      @(negedge clk);
      valid = 1'b1; ren = r; wen = w; funct3 = f3; addr = a; wdata = wd;
      #1;
      chk("accept_stall", stall, legal);
      chk("idle_no_req", mem_req, 0);
      @(negedge clk);
      valid = 1'b0; ren = 1'b0; wen = 1'b0; addr = $urandom; wdata = $urandom;
      #1;
      if (!legal) begin
         chk("fault_pulse", fault, 1);
         chk("fault_no_req", mem_req, 0);
         chk("fault_no_stall", stall, 0);
         chk("fault_no_valid", ovalid, 0);
         @(negedge clk); #1;
         chk("fault_one_cycle", fault, 0);
         chk("fault_rdata_hold", rdata, exp_rdata);
         return;
      end
      for (int c = 0; c <= gdly; c++) begin
         if (c > 0) @(negedge clk);
         gnt       = (c == gdly);
         rvalid    = (c == gdly) ? (r && rdly == 0) : 1'($urandom % 2);
         mem_rdata = (c == gdly) ? rd : $urandom;
         #1;
         chk("req_high", mem_req, 1);
         chk("req_stall", stall, 1);
         chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
         chk("req_we", mem_we, w);
         chk("req_mask", mem_mask, exp_mask(f3, a));
         if (w) chk("req_wdata", mem_wdata, exp_wdata(f3, wd));
      end
      @(negedge clk);
      gnt = 1'b0; rvalid = 1'b0;
      if (r && rdly != 0) begin
         nk = (rdly < 0) ? 4 : rdly;
         for (int k = 1; k <= nk; k++) begin
            if (k > 1) @(negedge clk);
            rvalid = (k == rdly); mem_rdata = rd;
            #1;
            chk("wait_no_req", mem_req, 0);
            chk("wait_stall", stall, 1);
         end
         @(negedge clk);
         rvalid = 1'b0;
         if (rdly < 0) begin
            exp_rdata = 32'd0;
            #1;
            chk("timeout_fault", fault, 1);
            chk("timeout_no_valid", ovalid, 0);
            chk("timeout_no_stall", stall, 0);
            chk("timeout_rdata", rdata, 32'd0);
            rvalid = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            rvalid = 1'b0;
            #1;
            chk("late_rvalid_no_valid", ovalid, 0);
            chk("late_rvalid_no_fault", fault, 0);
            chk("late_rvalid_rdata", rdata, 32'd0);
            @(negedge clk); #1;
            chk("late_rvalid_idle", ovalid, 0);
            return;
         end
      end
      #1;
      if (r) exp_rdata = exp_load(f3, a, rd);
      chk("resp_valid", ovalid, 1);
      chk("resp_no_stall", stall, 0);
      chk("resp_no_fault", fault, 0);
      chk("resp_rdata", rdata, exp_rdata);
      @(negedge clk); #1;
      chk("valid_one_cycle", ovalid, 0);
      chk("rdata_hold", rdata, exp_rdata);
   endtask

   initial begin
      bit          r;
      logic [2:0]  f3;
      logic [31:0] a;
      rst = 1'b1; valid = 1'b0; ren = 1'b0; wen = 1'b0; funct3 = 3'd0;
      addr = 32'd0; wdata = 32'd0; gnt = 1'b0; rvalid = 1'b0; mem_rdata = 32'd0;
      #12;
      chk("rst_stall", stall, 0);
      chk("rst_valid", ovalid, 0);
      chk("rst_fault", fault, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mask", mem_mask, 0);
      @(negedge clk);
      rst = 1'b0;

      run_access(1, 0, 3'b010, 32'h1000, 0, 32'hDEADBEEF, 0, 2);
      chk("lw_rdata_const", rdata, 32'hDEADBEEF);
      chk("lw_addr_const", mem_addr, 32'h1000);
      chk("lw_mask_const", mem_mask, 4'b1111);
      run_access(1, 0, 3'b000, 32'h2003, 0, 32'h80FF0000, 1, 1);
      chk("lb_const", rdata, 32'hFFFFFF80);
      run_access(1, 0, 3'b100, 32'h2003, 0, 32'h80FF0000, 0, 0);
      chk("lbu_const", rdata, 32'h00000080);
      run_access(1, 0, 3'b001, 32'h2002, 0, 32'h80FF0000, 2, 4);
      chk("lh_const", rdata, 32'hFFFF80FF);
      run_access(0, 1, 3'b000, 32'h3001, 32'h123456AB, 0, 0, 0);
      chk("sb_mask_const", mem_mask, 4'b0010);
      chk("sb_wdata_const", mem_wdata, 32'hABABABAB);
      chk("sb_rdata_kept", rdata, 32'hFFFF80FF);
      run_access(0, 1, 3'b001, 32'h3002, 32'hCAFE1234, 0, 1, 0);
      chk("sh_mask_const", mem_mask, 4'b1100);

      run_access(1, 0, 3'b010, 32'h4002, 0, 0, 0, 0);
      run_access(1, 1, 3'b010, 32'h4000, 0, 0, 0, 0);
      run_access(0, 1, 3'b100, 32'h4000, 0, 0, 0, 0);
      run_access(1, 0, 3'b011, 32'h4000, 0, 0, 0, 0);
      run_access(1, 0, 3'b101, 32'h4001, 0, 0, 0, 0);

      run_access(1, 0, 3'b010, 32'h5000, 0, 32'h11111111, 0, -1);

      // Reset while the request is on the bus, then while waiting for read data.
      @(negedge clk);
      valid = 1'b1; ren = 1'b1; funct3 = 3'b010; addr = 32'h6000;
      @(negedge clk);
      valid = 1'b0; ren = 1'b0;
      #1;
      chk("pre_rst_req", mem_req, 1);
      rst = 1'b1;
      #1;
      chk("rst_req_drop", mem_req, 0);
      chk("rst_req_stall", stall, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      valid = 1'b1; ren = 1'b1; funct3 = 3'b010; addr = 32'h6004;
      @(negedge clk);
      valid = 1'b0; ren = 1'b0; gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      #1;
      chk("wait_before_rst", stall, 1);
      rst = 1'b1;
      #1;
      exp_rdata = 32'd0;
      chk("rst_wait_req", mem_req, 0);
      chk("rst_wait_stall", stall, 0);
      chk("rst_wait_valid", ovalid, 0);
      chk("rst_wait_fault", fault, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("post_rst_valid", ovalid, 0);
      chk("post_rst_fault", fault, 0);
      run_access(1, 0, 3'b010, 32'h6008, 0, 32'h0BADF00D, 0, 1);

      for (int i = 0; i < 60; i++) begin
         r  = 1'($urandom % 2);
         f3 = 3'($urandom % 8);
         if ($urandom % 4 != 0) f3 = r ? 3'($urandom_range(0, 2) | (($urandom % 2) << 2))
                                     : 3'($urandom_range(0, 2));
         if (f3 == 3'b110) f3 = 3'b100;
         a = $urandom;
         if ($urandom % 3 != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
         if ($urandom % 10 == 0)
            run_access(1, 1, f3, a, $urandom, $urandom, 0, 0);
         else
            run_access(r, !r, f3, a, $urandom, $urandom, $urandom_range(0, 2),
                       ($urandom % 8 == 0) ? -1 : $urandom_range(0, 4));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store engine for the RV32I pipeline; sits between the EX/MEM pipeline register and the data-memory bus.
- Converts one load/store per instruction into a req/gnt/rvalid bus transaction.
- Generates byte masks for stores.
- Aligns and sign/zero-extends load data; this is the 32-bit memory-data word consumed by the writeback select.
- Holds the pipeline with o_stall while the bus is busy.

Parameters:
- MAX_WAIT, 255, max cycles in WAIT before a bus timeout fault (1..255, 8-bit counter).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_valid  in  1  instruction in MEM stage is valid.
- i_ren  in  1  load.
- i_wen  in  1  store.
- i_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  in  32  byte address from ALU.
- i_wdata  in  32  store data (rs2).
- o_stall  out  1  freeze IF..MEM this cycle.
- o_valid  out  1  one-cycle completion pulse.
- o_rdata  out  32  extended load data to writeback.
- o_fault  out  1  one-cycle pulse: misaligned, illegal, or timeout.
- o_mem_req  out  1  bus request.
- o_mem_we  out  1  1 = write.
- o_mem_addr  out  32  word address (addr[1:0]=00).
- o_mem_wdata  out  32  lane-shifted store data.
- o_mem_mask  out  4  byte enables.
- i_mem_gnt  in  1  request accepted.
- i_mem_rvalid  in  1  read data valid.
- i_mem_rdata  in  32  read word.

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0; o_rdata 0; wait counter 0. Reset mid-transaction drops o_mem_req immediately. No completion or fault pulse for the aborted access.
- States: IDLE, REQ, WAIT, RESP.
- IDLE, accept condition: i_valid & (i_ren ^ i_wen), funct3 legal for the op, address aligned.
  - On accept: latch addr, funct3, op, shifted wdata and mask; o_stall=1 combinationally in the same cycle; next state REQ.
- IDLE, fault condition: i_valid & (i_ren & i_wen), illegal funct3 (011, 11x; stores 1xx also illegal), or misaligned (H: addr[0]≠0; W: addr[1:0]≠0).
  - Response: o_fault=1 next cycle; no bus activity; o_valid stays 0; no stall.
- REQ: o_mem_req=1 with stable addr/we/wdata/mask until i_mem_gnt.
  - Store with gnt: next state RESP (posted write).
  - Load with gnt and no rvalid: next state WAIT, counter cleared.
  - Load with gnt and rvalid in the same cycle: capture data, next state RESP.
  - rvalid without gnt is ignored.
- WAIT: o_mem_req=0; counter increments each cycle.
  - On rvalid: capture data, next state RESP.
  - If counter reaches MAX_WAIT with no rvalid: o_fault=1, o_rdata=0, next state IDLE.
- RESP: o_valid=1 for exactly one cycle; o_stall=0; o_rdata holds until the next load completes; next state IDLE.
- o_stall is 1 in REQ and WAIT, and in IDLE on an accepting cycle.
- o_stall is 0 in RESP and on IDLE faults.
- Store lanes:
  - SB: mask = 0001 << addr[1:0]; data byte replicated ×4.
  - SH: mask 0011 or 1100; halfword replicated ×2.
  - SW: mask 1111.
- Load extract:
  - Byte at rdata[8*addr[1:0]+:8].
  - Half at rdata[16*addr[1]+:16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- rvalid in IDLE or RESP (stale, e.g. after a reset or timeout) is ignored.
- Throughput: one access per 3 cycles minimum (accept, REQ with gnt, RESP).

Decomposition:
- Shared package mem_pkg:
  - funct3 constants F3_B/H/W/BU/HU.
  - state enum.
  - MASK_* constants.
- One natural combinational sub-module load_align (funct3, addr[1:0], rdata -> o_rdata), reused by any future load path.

Test Plan:
- LW addr 0x1000, gnt at cycle 1, rvalid at cycle 3 with rdata 0xDEADBEEF -> o_mem_addr 0x1000, mask 1111, we 0; o_valid one cycle, o_rdata 0xDEADBEEF; o_stall high exactly until RESP.
- LB addr 0x2003 with rdata 0x80FF_0000 -> o_rdata 0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x2002 -> 0xFFFF80FF.
- SB addr 0x3001, wdata 0x123456AB, gnt in the same REQ cycle -> mask 0010, o_mem_wdata 0xABABABAB, o_valid two cycles after accept, no rvalid needed.
- Misaligned and illegal accesses:
  - LW at 0x4002 -> o_fault pulse, o_mem_req never asserted, o_stall 0.
  - i_ren=i_wen=1 -> o_fault pulse.
- Timeout with MAX_WAIT=4: load granted, no rvalid -> o_fault after 4 WAIT cycles; o_rdata 0; back to IDLE. A late rvalid is then ignored and o_valid stays 0.
- Assert i_rst during WAIT -> o_mem_req, o_stall, o_valid, o_fault all 0 immediately (asynchronous). Next load proceeds normally.
